// File: rtl/flash_seq_pkg.sv
// Shared types and constants for the multi-region flash read sequencer.
package flash_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } seq_state_e;

  localparam logic [1:0] MODE_STD     = 2'b00;
  localparam logic [1:0] MODE_DUAL    = 2'b01;
  localparam logic [1:0] MODE_QUAD    = 2'b10;
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;

  localparam logic [1:0] ERR_NONE       = 2'b00;
  localparam logic [1:0] ERR_BAD_REGION = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT    = 2'b10;
  localparam logic [1:0] ERR_ABORT      = 2'b11;

endpackage

// File: rtl/flash_seq_timer.sv
// Per-read watchdog: cleared on each launch, counts while waiting, flags expiry
// TIMEOUT_CYCLES cycles after the clear cycle.
module flash_seq_timer
  import flash_seq_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic system_clk,
  input  logic system_reset_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  logic [23:0] count;

  always_ff @(posedge system_clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en && !expired) begin
      count <= count + 24'd1;
    end
  end

  // The first waiting cycle sees count 0, so expiry lands on the Nth cycle after the clear.
  assign expired = count_en && (count >= (TIMEOUT_CYCLES - 24'd1));

endmodule

// File: rtl/flash_region_sequencer.sv
// Walks a table of flash regions, launching one engine read per enabled region.
// Optional FLASH_SEQ_TIMEOUT_EN adds the per-read timeout with retry.
module flash_region_sequencer
  import flash_seq_pkg::*;
#(
  parameter int          NUM_REGIONS    = 4,
  parameter int          ADDR_W         = 32,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000,
  parameter int          MAX_RETRY      = 2,
  localparam int         IDX_W          = $clog2(NUM_REGIONS + 1)
) (
  input  logic                          system_clk,
  input  logic                          system_reset_n,
  input  logic                          start_flag,
  input  logic                          abort,
  input  logic [NUM_REGIONS-1:0]        region_en,
  input  logic [NUM_REGIONS*ADDR_W-1:0] region_start_addr,
  input  logic [NUM_REGIONS*ADDR_W-1:0] region_end_addr,
  input  logic [NUM_REGIONS*2-1:0]      region_mode,
  output logic                          eng_start,
  output logic [ADDR_W-1:0]             eng_start_addr,
  output logic [ADDR_W-1:0]             eng_end_addr,
  output logic [1:0]                    eng_mode,
  input  logic                          eng_done,
  output logic                          busy,
  output logic                          completed,
  output logic [IDX_W-1:0]              cur_region,
  output logic [1:0]                    err_code,
  output logic [IDX_W-1:0]              err_region
);

  seq_state_e        state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [ADDR_W-1:0] start_addr_nxt, end_addr_nxt;
  logic [1:0]        mode_nxt;
  logic              completed_nxt;
  logic [1:0]        err_code_nxt;
  logic [IDX_W-1:0]  err_region_nxt;

  logic              sel_en;
  logic [ADDR_W-1:0] sel_start, sel_end;
  logic [1:0]        sel_mode;
  logic              timer_expired;
  logic              retry_ok;

  always_comb begin
    sel_en    = 1'b0;
    sel_start = '0;
    sel_end   = '0;
    sel_mode  = MODE_STD;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (idx == IDX_W'(i)) begin
        sel_en    = region_en[i];
        sel_start = region_start_addr[i*ADDR_W +: ADDR_W];
        sel_end   = region_end_addr[i*ADDR_W +: ADDR_W];
        sel_mode  = region_mode[i*2 +: 2];
      end
    end
  end

`ifdef FLASH_SEQ_TIMEOUT_EN
  localparam int RETRY_W = $clog2(MAX_RETRY + 2);

  logic [RETRY_W-1:0] retry_cnt;

  flash_seq_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .system_clk    (system_clk),
    .system_reset_n(system_reset_n),
    .clear         (state == ST_ISSUE),
    .count_en      (state == ST_WAIT),
    .expired       (timer_expired)
  );

  always_ff @(posedge system_clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      retry_cnt <= '0;
    end else if (state == ST_SCAN) begin
      retry_cnt <= '0;
    end else if (state == ST_WAIT && !abort && !eng_done && timer_expired && retry_ok) begin
      retry_cnt <= retry_cnt + RETRY_W'(1);
    end
  end

  assign retry_ok = (retry_cnt < RETRY_W'(MAX_RETRY));
`else
  assign timer_expired = 1'b0;
  assign retry_ok      = 1'b0;
`endif

  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    start_addr_nxt = eng_start_addr;
    end_addr_nxt   = eng_end_addr;
    mode_nxt       = eng_mode;
    completed_nxt  = completed;
    err_code_nxt   = err_code;
    err_region_nxt = err_region;
    // Abort outranks completion and timeout arriving in the same cycle.
    if (state != ST_IDLE && abort) begin
      state_nxt      = ST_IDLE;
      err_code_nxt   = ERR_ABORT;
      err_region_nxt = idx;
      completed_nxt  = 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start_flag) begin
            idx_nxt       = '0;
            completed_nxt = 1'b0;
            err_code_nxt  = ERR_NONE;
            state_nxt     = ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (idx == IDX_W'(NUM_REGIONS)) begin
            state_nxt = ST_DONE;
          end else if (!sel_en) begin
            idx_nxt = idx + IDX_W'(1);
          end else if (sel_end < sel_start || sel_mode == MODE_ILLEGAL) begin
            err_code_nxt   = ERR_BAD_REGION;
            err_region_nxt = idx;
            state_nxt      = ST_IDLE;
          end else begin
            start_addr_nxt = sel_start;
            end_addr_nxt   = sel_end;
            mode_nxt       = sel_mode;
            state_nxt      = ST_ISSUE;
          end
        end
        ST_ISSUE: state_nxt = ST_WAIT;
        ST_WAIT: begin
          if (eng_done) begin
            idx_nxt   = idx + IDX_W'(1);
            state_nxt = ST_SCAN;
          end else if (timer_expired) begin
            if (retry_ok) begin
              state_nxt = ST_ISSUE;
            end else begin
              err_code_nxt   = ERR_TIMEOUT;
              err_region_nxt = idx;
              state_nxt      = ST_IDLE;
            end
          end
        end
        ST_DONE: begin
          completed_nxt = 1'b1;
          state_nxt     = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge system_clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state          <= ST_IDLE;
      idx            <= '0;
      eng_start_addr <= '0;
      eng_end_addr   <= '0;
      eng_mode       <= MODE_STD;
      completed      <= 1'b0;
      err_code       <= ERR_NONE;
      err_region     <= '0;
    end else begin
      state          <= state_nxt;
      idx            <= idx_nxt;
      eng_start_addr <= start_addr_nxt;
      eng_end_addr   <= end_addr_nxt;
      eng_mode       <= mode_nxt;
      completed      <= completed_nxt;
      err_code       <= err_code_nxt;
      err_region     <= err_region_nxt;
    end
  end

  assign busy       = (state != ST_IDLE);
  assign eng_start  = (state == ST_ISSUE);
  assign cur_region = idx;

endmodule

// File: tb/tb_flash_region_sequencer.sv
// Randomized and directed bench for flash_region_sequencer with a transaction-level
// model of which regions get launched and how the sequence ends.
module tb_flash_region_sequencer;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int MR = 2;
  localparam int IW = $clog2(NR + 1);
`ifdef FLASH_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              system_clk = 1'b0;
  logic              system_reset_n = 1'b0;
  logic              start_flag = 1'b0;
  logic              abort_main = 1'b0;
  logic              abort_eng = 1'b0;
  logic              abort;
  logic [NR-1:0]     region_en = '0;
  logic [NR*AW-1:0]  region_start_addr = '0;
  logic [NR*AW-1:0]  region_end_addr = '0;
  logic [NR*2-1:0]   region_mode = '0;
  logic              eng_start;
  logic [AW-1:0]     eng_start_addr, eng_end_addr;
  logic [1:0]        eng_mode;
  logic              eng_done = 1'b0;
  logic              busy, completed;
  logic [IW-1:0]     cur_region, err_region;
  logic [1:0]        err_code;

  assign abort = abort_main | abort_eng;

  flash_region_sequencer #(
    .NUM_REGIONS   (NR),
    .ADDR_W        (AW),
    .TIMEOUT_CYCLES(24'd100),
    .MAX_RETRY     (MR)
  ) dut (
    .system_clk       (system_clk),
    .system_reset_n   (system_reset_n),
    .start_flag       (start_flag),
    .abort            (abort),
    .region_en        (region_en),
    .region_start_addr(region_start_addr),
    .region_end_addr  (region_end_addr),
    .region_mode      (region_mode),
    .eng_start        (eng_start),
    .eng_start_addr   (eng_start_addr),
    .eng_end_addr     (eng_end_addr),
    .eng_mode         (eng_mode),
    .eng_done         (eng_done),
    .busy             (busy),
    .completed        (completed),
    .cur_region       (cur_region),
    .err_code         (err_code),
    .err_region       (err_region)
  );

  always #5 system_clk = ~system_clk;

  int cyc = 0;
  always @(posedge system_clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          region;
    logic [AW-1:0] sa;
    logic [AW-1:0] ea;
    logic [1:0]  mode;
  } launch_t;

  launch_t       launches[$];
  logic [NR-1:0] tb_en;
  logic [AW-1:0] tb_sa[NR];
  logic [AW-1:0] tb_ea[NR];
  logic [1:0]    tb_md[NR];
  logic [7:0]    silent_mask = '0;
  int            abort_region = -1;
  int            eng_lat = 50;
  int            start_cyc = 0;

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Engine model: records every launch, answers after eng_lat cycles unless silenced.
  initial begin
    int pend = 0;
    int pend_region = 0;
    forever begin
      @(negedge system_clk);
      eng_done  = 1'b0;
      abort_eng = 1'b0;
      if (!system_reset_n) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            eng_done = 1'b1;
            if (pend_region == abort_region) abort_eng = 1'b1;
          end
        end
        if (eng_start) begin
          launches.push_back('{cyc, int'(cur_region), eng_start_addr, eng_end_addr, eng_mode});
          if (!silent_mask[cur_region]) begin
            pend        = eng_lat;
            pend_region = int'(cur_region);
          end
        end
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic apply_table();
    for (int i = 0; i < NR; i++) begin
      region_start_addr[i*AW +: AW] = tb_sa[i];
      region_end_addr[i*AW +: AW]   = tb_ea[i];
      region_mode[i*2 +: 2]         = tb_md[i];
    end
    region_en = tb_en;
  endtask

  int         exp_q[$];
  logic [1:0] exp_err;
  int         exp_err_reg;
  bit         exp_comp;

  // Expected outcome from the table rules: walk regions in order, skip disabled,
  // stop on a bad entry, a silent engine, or an abort tied to a region's completion.
  function automatic void build_model();
    exp_q.delete();
    exp_err     = 2'b00;
    exp_err_reg = 0;
    exp_comp    = 1'b0;
    for (int i = 0; i < NR; i++) begin
      if (!tb_en[i]) continue;
      if (tb_ea[i] < tb_sa[i] || tb_md[i] == 2'b11) begin
        exp_err = 2'b01; exp_err_reg = i; return;
      end
      if (silent_mask[i]) begin
        repeat (TO_EN ? 1 + MR : 1) exp_q.push_back(i);
        exp_err = 2'b10; exp_err_reg = i; return;
      end
      exp_q.push_back(i);
      if (abort_region == i) begin
        exp_err = 2'b11; exp_err_reg = i; return;
      end
    end
    exp_comp = 1'b1;
  endfunction

  task automatic pulse_start();
    @(negedge system_clk);
    start_flag = 1'b1;
    start_cyc  = cyc;
    @(negedge system_clk);
    start_flag = 1'b0;
  endtask

  task automatic run_seq(input string name, input int budget);
    int k = 0;
    launches.delete();
    apply_table();
    pulse_start();
    check({name, ":busy_after_start"}, busy, 1);
    check({name, ":completed_cleared"}, completed, 0);
    while (busy && k < budget) begin
      @(negedge system_clk);
      k++;
    end
    check({name, ":sequence_ended"}, busy, 0);
  endtask

  task automatic compare_result(input string name);
    build_model();
    check({name, ":n_launch"}, launches.size(), exp_q.size());
    for (int j = 0; j < launches.size() && j < exp_q.size(); j++) begin
      int r = exp_q[j];
      check({name, ":region"}, launches[j].region, r);
      check({name, ":start_addr"}, launches[j].sa, tb_sa[r]);
      check({name, ":end_addr"}, launches[j].ea, tb_ea[r]);
      check({name, ":mode"}, launches[j].mode, tb_md[r]);
    end
    check({name, ":err_code"}, err_code, exp_err);
    check({name, ":completed"}, completed, exp_comp);
    if (exp_err != 2'b00) check({name, ":err_region"}, err_region, exp_err_reg);
  endtask

  task automatic default_table();
    tb_en = '1;
    for (int i = 0; i < NR; i++) begin
      tb_sa[i] = 32'h0001_0000 * (i + 1);
      tb_ea[i] = tb_sa[i] + 32'h0000_0FFF;
    end
    tb_md[0] = 2'b00; tb_md[1] = 2'b01; tb_md[2] = 2'b10; tb_md[3] = 2'b00;
  endtask

  task automatic check_reset_values(input string name);
    check({name, ":busy"}, busy, 0);
    check({name, ":eng_start"}, eng_start, 0);
    check({name, ":completed"}, completed, 0);
    check({name, ":err_code"}, err_code, 0);
    check({name, ":err_region"}, err_region, 0);
    check({name, ":cur_region"}, cur_region, 0);
    check({name, ":eng_start_addr"}, eng_start_addr, 0);
    check({name, ":eng_end_addr"}, eng_end_addr, 0);
    check({name, ":eng_mode"}, eng_mode, 0);
  endtask

  initial begin
    default_table();
    apply_table();
    #1;
    check_reset_values("reset");
    repeat (3) @(negedge system_clk);
    system_reset_n = 1'b1;
    repeat (2) @(negedge system_clk);

    // All four regions, modes 00/01/10/00, engine answers after 50 cycles.
    eng_lat = 50;
    run_seq("all4", 2000);
    compare_result("all4");
    if (launches.size() > 0) check("all4:first_launch_latency", launches[0].cyc - start_cyc, 2);

    // Only regions 1 and 3 enabled.
    tb_en = 4'b1010;
    run_seq("en1010", 2000);
    compare_result("en1010");

    // Region 2 inverted range.
    default_table();
    tb_sa[2] = 32'h200; tb_ea[2] = 32'h100;
    run_seq("bad2", 2000);
    compare_result("bad2");

    // Region 1 illegal mode.
    default_table();
    tb_md[1] = 2'b11;
    run_seq("illegal1", 2000);
    compare_result("illegal1");

    // Silent engine on region 0.
    default_table();
    silent_mask = 8'h01;
    if (TO_EN) begin
      run_seq("timeout", 1000);
      compare_result("timeout");
      for (int j = 1; j < launches.size(); j++)
        check("timeout:retry_spacing", launches[j].cyc - launches[j-1].cyc, 101);
    end else begin
      launches.delete();
      apply_table();
      pulse_start();
      repeat (400) @(negedge system_clk);
      check("notimeout:n_launch", launches.size(), 1);
      check("notimeout:still_busy", busy, 1);
      abort_main = 1'b1;
      @(negedge system_clk);
      abort_main = 1'b0;
      check("notimeout:abort_busy", busy, 0);
      check("notimeout:abort_err", err_code, 2'b11);
      check("notimeout:abort_region", err_region, 0);
      check("notimeout:abort_completed", completed, 0);
    end
    silent_mask = '0;

    // Abort arriving together with eng_done for region 1.
    default_table();
    abort_region = 1;
    run_seq("abort_done", 2000);
    compare_result("abort_done");
    check("abort_done:cur_region", cur_region, 1);
    abort_region = -1;

    // Extra start while busy, then asynchronous reset mid-WAIT.
    default_table();
    silent_mask = 8'h01;
    launches.delete();
    apply_table();
    pulse_start();
    repeat (5) @(negedge system_clk);
    start_flag = 1'b1;
    @(negedge system_clk);
    start_flag = 1'b0;
    repeat (3) @(negedge system_clk);
    check("restart:n_launch", launches.size(), 1);
    check("restart:busy", busy, 1);
    #2;
    system_reset_n = 1'b0;
    #1;
    check_reset_values("midreset");
    @(negedge system_clk);
    system_reset_n = 1'b1;
    silent_mask = '0;
    launches.delete();
    repeat (150) @(negedge system_clk);
    check("postreset:no_launch", launches.size(), 0);
    check("postreset:busy", busy, 0);
    run_seq("postreset_run", 2000);
    compare_result("postreset_run");

    // Randomized tables and engine latencies.
    for (int t = 0; t < 10; t++) begin
      tb_en = NR'($urandom);
      for (int i = 0; i < NR; i++) begin
        tb_sa[i] = $urandom | 32'h0000_1000;
        if ($urandom_range(0, 5) == 0) tb_ea[i] = tb_sa[i] - 32'($urandom_range(1, 4095));
        else                           tb_ea[i] = tb_sa[i] + 32'($urandom_range(0, 4096));
        if (tb_ea[i] < tb_sa[i] && $urandom_range(0, 1) == 0) tb_ea[i] = tb_sa[i];
        tb_md[i] = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      end
      eng_lat = $urandom_range(1, 60);
      run_seq("random", 2000);
      compare_result("random");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
